// File: rtl/md_unit_e.sv
// Stage-E multiply/divide unit holding the HI/LO pair.
// Results are computed at accept and released to HI/LO after a fixed busy window.
module md_unit_e #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        tmp_hi;
  logic [31:0]        tmp_lo;
  logic               div_zero;

  logic               accept;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [63:0]        prod;
  logic               is_signed;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        dvd;
  logic [31:0]        dvs_raw;
  logic [31:0]        dvs;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        quot;
  logic [31:0]        rem;

  assign accept   = start & ~busy & ~flush;
  assign stall_md = busy | (start & (op <= 3'd3));

  // Truncated 64-bit products; sign extension makes the low 64 bits the signed result.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign prod   = op[0] ? prod_u : prod_s;

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
  assign is_signed = ~op[0];
  assign a_neg     = is_signed & A[31];
  assign b_neg     = is_signed & B[31];
  assign dvd       = a_neg ? (~A + 32'd1) : A;
  assign dvs_raw   = b_neg ? (~B + 32'd1) : B;
  assign dvs       = (B == 32'd0) ? 32'd1 : dvs_raw;
  assign q_mag     = dvd / dvs;
  assign r_mag     = dvd % dvs;
  assign quot      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem       = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      tmp_hi   <= '0;
      tmp_lo   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              3'd0, 3'd1: begin
                tmp_hi <= prod[63:32];
                tmp_lo <= prod[31:0];
                cnt    <= CNT_W'(MULT_CYCLES - 1);
                busy   <= 1'b1;
                state  <= MUL;
              end
              3'd2, 3'd3: begin
                tmp_hi   <= rem;
                tmp_lo   <= quot;
                div_zero <= (B == 32'd0);
                cnt      <= CNT_W'(DIV_CYCLES - 1);
                busy     <= 1'b1;
                state    <= DIV;
              end
              3'd4:    HI <= A;
              3'd5:    LO <= A;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            // Divide by zero still spends the full window but leaves HI/LO alone.
            if (!(state == DIV && div_zero)) begin
              HI <= tmp_hi;
              LO <= tmp_lo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_e.sv
// Directed bench for md_unit_e: latency, results, mthi/mtlo, ignored starts,
// divide-by-zero/overflow, mid-op reset and flush.
module tb_md_unit_e;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks   = 0;
  int failures = 0;
  int n;

  md_unit_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .flush    (flush),
    .busy     (busy),
    .stall_md (stall_md),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts negedge samples with busy high, bounded so a stuck busy cannot hang.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // Drives one op for a single cycle, leaving the bench at the sample after accept.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 3'd7; A = '0; B = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);

    // mult 3 * -5
    start = 1'b1; op = 3'd0; A = 32'd3; B = 32'hFFFF_FFFB;
    #1 chk("mult_stall_start", 32'(stall_md), 32'd1);
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    chk("mult_stall_busy", 32'(stall_md), 32'd1);
    wait_idle(n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFF1);

    // multu 0xFFFFFFFF * 2
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    chk("multu_cycles", 32'(n), 32'd5);
    chk("multu_hi", HI, 32'd1);
    chk("multu_lo", LO, 32'hFFFF_FFFE);

    // divu 100 / 7
    issue(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_cycles", 32'(n), 32'd10);
    chk("divu_lo", LO, 32'd14);
    chk("divu_hi", HI, 32'd2);

    // div -7 / 2
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", 32'(n), 32'd10);
    chk("div_lo", LO, 32'hFFFF_FFFD);
    chk("div_hi", HI, 32'hFFFF_FFFF);

    // mthi then mtlo back-to-back
    start = 1'b1; op = 3'd4; A = 32'h1234;
    @(negedge clk);
    op = 3'd5; A = 32'h5678;
    chk("mthi_busy", 32'(busy), 32'd0);
    chk("mthi_hi", HI, 32'h1234);
    chk("mtlo_stall", 32'(stall_md), 32'd0);
    @(negedge clk);
    start = 1'b0; op = 3'd7;
    chk("mtlo_busy", 32'(busy), 32'd0);
    chk("mtlo_hi", HI, 32'h1234);
    chk("mtlo_lo", LO, 32'h5678);

    // start during busy mult is ignored, operand changes have no effect
    issue(3'd0, 32'd7, 32'd6);
    start = 1'b1; op = 3'd5; A = 32'd9; B = 32'd100;
    #1 chk("ign_stall", 32'(stall_md), 32'd1);
    wait_idle(n);
    start = 1'b0; op = 3'd7;
    chk("ign_cycles", 32'(n), 32'd5);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd42);

    // divide by zero keeps HI/LO
    issue(3'd4, 32'hAAAA, 32'd0);
    issue(3'd5, 32'hAAAA, 32'd0);
    issue(3'd2, 32'd5, 32'd0);
    wait_idle(n);
    chk("dz_cycles", 32'(n), 32'd10);
    chk("dz_hi", HI, 32'hAAAA);
    chk("dz_lo", LO, 32'hAAAA);

    // signed overflow case
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_cycles", 32'(n), 32'd10);
    chk("ovf_lo", LO, 32'h8000_0000);
    chk("ovf_hi", HI, 32'd0);

    // reset while cnt==2 of a divide
    issue(3'd2, 32'd100, 32'd3);
    repeat (7) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    chk("midrst_hi_late", HI, 32'd0);
    chk("midrst_lo_late", LO, 32'd0);

    // start with flush is dropped
    issue(3'd4, 32'h55, 32'd0);
    flush = 1'b1;
    issue(3'd0, 32'd3, 32'd4);
    chk("flush_busy", 32'(busy), 32'd0);
    issue(3'd4, 32'h99, 32'd0);
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy2", 32'(busy), 32'd0);
    chk("flush_hi", HI, 32'h55);
    chk("flush_lo", LO, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
